// File: rtl/id_hazard_scheduler.sv
// -----------------------------------------------------------------------------
// id_hazard_scheduler
//
// Hazard controller that sits beside the ID stage of the 5-stage core. It keeps
// a shadow copy of the destination-register information of the instructions
// currently in EX, MEM and WB. It compares that copy with the source registers
// of the instruction in ID, and from the result it produces the stall and flush
// controls for the IF/ID and ID/EX pipeline registers.
//
// Hazards handled, in priority order:
//   1. Data-memory wait states (mem_busy): the whole pipeline holds.
//   2. A taken branch or jump resolved in EX: IF/ID and ID/EX are flushed.
//   3. A data hazard on an ID source register: a load-use hazard, or any
//      pending write when forwarding is absent. IF and ID hold, and a bubble
//      goes into EX.
//
// Parameters:
//   FWD_EN         1 = EX/MEM forwarding exists, so only a load-use stalls;
//                  0 = stall on any pending write in EX or MEM
//   RF_WRITE_FIRST 1 = the register file passes a same-cycle WB write to ID;
//                  0 = a match against the WB slot also stalls
//   CNT_WIDTH      width of each saturating performance counter
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   rs1_ID/rs2_ID              source registers of the ID instruction
//   rs1_used_ID/rs2_used_ID    the ID instruction really reads that source
//   rd_ID, reg_write_ID        destination of the ID instruction
//   result_sel_ID              result select; 2'b01 marks a load
//   pc_src_EX                  taken branch or jump resolved in EX
//   mem_busy                   data memory not ready
//   stall_IF, stall_ID         hold the PC and the IF/ID register
//   flush_ID, flush_EX         load a bubble into IF/ID and ID/EX
//   freeze_EX_MEM              hold ID/EX, EX/MEM and MEM/WB
//   load_use_cnt, flush_cnt    saturating event counters
//
// The control outputs are combinational so that they act in the same cycle as
// the hazard. Only the shadow slots and the counters are registered.
// -----------------------------------------------------------------------------
module id_hazard_scheduler #(
    parameter int FWD_EN         = 1,
    parameter int RF_WRITE_FIRST = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [4:0]           rs1_ID,
    input  logic [4:0]           rs2_ID,
    input  logic                 rs1_used_ID,
    input  logic                 rs2_used_ID,
    input  logic [4:0]           rd_ID,
    input  logic                 reg_write_ID,
    input  logic [1:0]           result_sel_ID,
    input  logic                 pc_src_EX,
    input  logic                 mem_busy,
    output logic                 stall_IF,
    output logic                 stall_ID,
    output logic                 flush_ID,
    output logic                 flush_EX,
    output logic                 freeze_EX_MEM,
    output logic [CNT_WIDTH-1:0] load_use_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    // Shadow slot for the instruction in EX. The load flag only matters while
    // the producer sits in EX: one stage later, forwarding or the write-back
    // path covers it. For that reason MEM and WB keep only valid/rd/wr.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } ex_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
    } late_slot_t;

    localparam ex_slot_t   EX_EMPTY   = '{valid: 1'b0, rd: 5'd0, wr: 1'b0, load: 1'b0};
    localparam late_slot_t LATE_EMPTY = '{valid: 1'b0, rd: 5'd0, wr: 1'b0};
    localparam logic [1:0] RES_LOAD   = 2'b01;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    ex_slot_t   ex_r;
    late_slot_t mem_r;
    late_slot_t wb_r;

    // Set one clock after reset is released. It keeps every control output low
    // during reset and on the first cycle after reset.
    logic init_done_r;

    logic rs1_ex_s,  rs2_ex_s;
    logic rs1_mem_s, rs2_mem_s;
    logic rs1_wb_s,  rs2_wb_s;
    logic raw_hazard_s;
    logic hazard_s;
    logic load_use_stall_s;

    // A source matches a slot only when the slot holds a real, writing
    // instruction whose destination is not x0.
    function automatic logic src_match(
        input logic       used,
        input logic [4:0] src,
        input logic       slot_valid,
        input logic       slot_wr,
        input logic [4:0] slot_rd
    );
        return used && slot_valid && slot_wr && (slot_rd != 5'd0) && (slot_rd == src);
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        logic [CNT_WIDTH-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // Compare the source registers of the ID instruction with the shadow slots.
    always_comb begin
        rs1_ex_s  = src_match(rs1_used_ID, rs1_ID, ex_r.valid,  ex_r.wr,  ex_r.rd);
        rs2_ex_s  = src_match(rs2_used_ID, rs2_ID, ex_r.valid,  ex_r.wr,  ex_r.rd);
        rs1_mem_s = src_match(rs1_used_ID, rs1_ID, mem_r.valid, mem_r.wr, mem_r.rd);
        rs2_mem_s = src_match(rs2_used_ID, rs2_ID, mem_r.valid, mem_r.wr, mem_r.rd);
        rs1_wb_s  = src_match(rs1_used_ID, rs1_ID, wb_r.valid,  wb_r.wr,  wb_r.rd);
        rs2_wb_s  = src_match(rs2_used_ID, rs2_ID, wb_r.valid,  wb_r.wr,  wb_r.rd);
    end

    // Build the hazard condition that fits the forwarding configuration.
    always_comb begin
        raw_hazard_s = 1'b0;
        if (FWD_EN != 0) begin
            // With forwarding, only a load still in EX cannot supply its result in time.
            raw_hazard_s = (rs1_ex_s || rs2_ex_s) && ex_r.load;
        end else begin
            raw_hazard_s = rs1_ex_s || rs2_ex_s || rs1_mem_s || rs2_mem_s;
        end
        if (RF_WRITE_FIRST == 0) begin
            raw_hazard_s = raw_hazard_s || rs1_wb_s || rs2_wb_s;
        end else begin
            raw_hazard_s = raw_hazard_s;
        end
        hazard_s = id_valid && raw_hazard_s;
    end

    // Choose the pipeline controls by priority: memory wait, then redirect,
    // then data hazard.
    always_comb begin
        stall_IF         = 1'b0;
        stall_ID         = 1'b0;
        flush_ID         = 1'b0;
        flush_EX         = 1'b0;
        freeze_EX_MEM    = 1'b0;
        load_use_stall_s = 1'b0;
        if (!init_done_r) begin
            stall_IF = 1'b0;
        end else if (mem_busy) begin
            // EX is frozen, so a pending redirect stays visible until the memory is ready.
            freeze_EX_MEM = 1'b1;
            stall_IF      = 1'b1;
            stall_ID      = 1'b1;
        end else if (pc_src_EX) begin
            // The ID instruction is being killed, so any hazard it has no longer matters.
            flush_ID = 1'b1;
            flush_EX = 1'b1;
        end else if (hazard_s) begin
            stall_IF         = 1'b1;
            stall_ID         = 1'b1;
            flush_EX         = 1'b1;
            load_use_stall_s = 1'b1;
        end else begin
            stall_IF = 1'b0;
        end
    end

    // Mark the first edge after reset, which enables the control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= 1'b1;
        end
    end

    // Advance the shadow pipeline together with the real one. A flushed slot
    // enters EX as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r  <= EX_EMPTY;
            mem_r <= LATE_EMPTY;
            wb_r  <= LATE_EMPTY;
        end else if (freeze_EX_MEM) begin
            ex_r  <= ex_r;
            mem_r <= mem_r;
            wb_r  <= wb_r;
        end else begin
            wb_r       <= mem_r;
            mem_r      <= '{valid: ex_r.valid, rd: ex_r.rd, wr: ex_r.wr};
            ex_r.valid <= id_valid && !flush_EX;
            ex_r.rd    <= rd_ID;
            ex_r.wr    <= reg_write_ID;
            ex_r.load  <= (result_sel_ID == RES_LOAD);
        end
    end

    // Count load-use stall cycles and control-flush events, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_use_cnt <= CNT_ZERO;
            flush_cnt    <= CNT_ZERO;
        end else begin
            if (load_use_stall_s) begin
                load_use_cnt <= sat_inc(load_use_cnt);
            end else begin
                load_use_cnt <= load_use_cnt;
            end
            if (flush_ID) begin
                flush_cnt <= sat_inc(flush_cnt);
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end

endmodule
